// File: rtl/ready_valid_fifo.sv
// ready_valid_fifo
//   First-word-fall-through FIFO with ready/valid handshakes on both sides.
//   Buffers a producer against stall windows of the downstream sink, reports
//   its occupancy, counts output-side stall cycles and flags producers that
//   withdraw or alter an offer before it was accepted.
//
// Parameters
//   WIDTH  data bits per word
//   DEPTH  number of storage entries (>= 2, any value, not only powers of two)
//   CW     width of the saturating stall counter
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept a word this cycle
//   in_data    write data
//   out_valid  head word is present on out_data
//   out_ready  sink accepts the head word this cycle
//   out_data   head word (combinational read of the head entry)
//   count      current occupancy, 0..DEPTH
//   stall_cnt  cycles with out_valid && !out_ready, saturating at all-ones
//   proto_err  sticky producer protocol violation flag, cleared by reset only

module ready_valid_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CW-1:0]                stall_cnt,
    output logic                         proto_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             en;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             offer_pend;
    logic [WIDTH-1:0] offer_data;
    logic             offer_broken;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    always_comb begin
        full      = (count == NW'(DEPTH));
        empty     = (count == '0);
        // No pass-through when full: a pop this cycle frees space only for the next one.
        in_ready  = en && !full;
        out_valid = !empty;
        out_data  = mem[rd_ptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // A pending unaccepted offer from last cycle must be repeated unchanged.
    always_comb begin
        offer_broken = offer_pend && (!in_valid || (in_data != offer_data));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            en <= 1'b1;
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offer_pend <= 1'b0;
            offer_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            offer_pend <= in_valid && !in_ready;
            offer_data <= in_data;
            if (offer_broken) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ready_valid_fifo.sv
module tb_ready_valid_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 5;
    localparam int unsigned SMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic [CW-1:0]    stall_cnt;
    logic             proto_err;

    ready_valid_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .stall_cnt(stall_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue of accepted words plus flags.
    logic [WIDTH-1:0] exp_q [$];
    logic             en_m    = 1'b0;
    int               stall_m = 0;
    logic             perr_m  = 1'b0;
    logic             pend_v  = 1'b0;
    logic [WIDTH-1:0] pend_d  = '0;
    logic             prod_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    always @(negedge rst_n) begin
        exp_q.delete();
        en_m    = 1'b0;
        stall_m = 0;
        perr_m  = 1'b0;
        pend_v  = 1'b0;
    end

    // Monitor: compares DUT state after the last edge with the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(en_m && (exp_q.size() < DEPTH)));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        chk("proto_err", 32'(proto_err), 32'(perr_m));
        if (exp_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
        end
    end

    // Observer: applies the handshakes of the coming edge to the model.
    always @(negedge clk) begin
        logic rdy;
        logic vld;
        #1;
        if (rst_n) begin
            rdy = en_m && (exp_q.size() < DEPTH);
            vld = (exp_q.size() != 0);
            if (pend_v && (!in_valid || in_data != pend_d)) perr_m = 1'b1;
            pend_v = in_valid && !rdy;
            pend_d = in_data;
            if (vld && !out_ready && stall_m < SMAX) stall_m++;
            if (vld && out_ready) void'(exp_q.pop_front());
            if (in_valid && rdy) exp_q.push_back(in_data);
            en_m = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        timeout("send");
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b0;

        // 1: reset with a producer already offering
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 0);
        tick();
        chk("en_in_ready", 32'(in_ready), 1);
        chk("en_count", 32'(count), 0);
        tick();
        chk("first_push_count", 32'(count), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // 2: single word, one cycle latency, immediate pop
        send(8'h11);
        chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_out_data", 32'(out_data), 32'h11);
        tick();
        chk("lat_count_after_pop", 32'(count), 0);

        // 3: fill while stalled, then release the sink
        out_ready = 1'b0;
        fork
            begin
                for (int d = 1; d <= 6; d++) send(8'(d));
            end
            begin
                repeat (8) tick();
                chk("full_count", 32'(count), 4);
                chk("full_in_ready", 32'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();

        // 4: steady push and pop at occupancy 2
        out_ready = 1'b0;
        send(8'hC0);
        send(8'hC1);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            out_ready = 1'b1;
            tick();
            chk("steady_count", 32'(count), 2);
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // 5: sink with 3-cycle ready-low windows
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(8'($urandom));
                end
                prod_done = 1'b1;
            end
            begin
                int c;
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
                for (c = 0; c < 2000 && !(prod_done && exp_q.size() == 0); c++) begin
                    @(negedge clk);
                    acc = out_valid && out_ready;
                    tick();
                    if (acc) begin
                        out_ready = 1'b0;
                        repeat (3) tick();
                        out_ready = 1'b1;
                    end
                end
                if (!(prod_done && exp_q.size() == 0)) timeout("sink_drain");
            end
        join

        // random traffic that respects the producer protocol
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && in_valid; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        if (in_valid) timeout("random_final_offer");
        in_valid = 1'b0;
        repeat (6) tick();

        // 6: long stall to saturation, broken offer, reset at count 3
        out_ready = 1'b0;
        for (int d = 0; d < 4; d++) send(8'(8'h20 + d));
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (40) tick();
        chk("stall_saturated", 32'(stall_cnt), SMAX);
        chk("held_no_err", 32'(proto_err), 0);
        in_data = 8'hBB;
        repeat (2) tick();
        chk("changed_offer_err", 32'(proto_err), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();
        chk("pre_rst_count", 32'(count), 3);
        chk("err_sticky", 32'(proto_err), 1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_count", 32'(count), 0);
        chk("async_proto_err", 32'(proto_err), 0);
        chk("async_stall", 32'(stall_cnt), 0);
        chk("async_in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
